// File: rtl/cpu_ctrl_pkg.sv
// Shared types and helpers for the CPU run/dump sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RST   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    SCAN  = 3'd4,
    WAIT  = 3'd5,
    OUT   = 3'd6,
    DONE  = 3'd7
  } state_t;

  localparam logic [4:0] HALT_OP = 5'b11100;

  // HALT is the opcode with an all-zero or all-one operand field; anything else keeps running.
  function automatic logic is_halt(input logic [15:0] instr, input logic [4:0] op);
    return (instr[15:11] == op) &&
           ((instr[10:0] == 11'h000) || (instr[10:0] == 11'h7FF));
  endfunction

endpackage

// File: rtl/mem_scan_streamer.sv
// Walks data memory from address 0 to the last address and streams nonzero words over valid/ready.
// The address never wraps; the last address ends the scan with a one-cycle scan_done.
module mem_scan_streamer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              scan_done
);
  import cpu_ctrl_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            st_r;
  state_t            st_next_s;
  logic [ADDR_W-1:0] addr_r;
  logic              rd_en_r;
  logic              valid_r;
  logic [ADDR_W-1:0] dump_addr_r;
  logic [DATA_W-1:0] dump_data_r;
  logic              last_s;
  logic              nonzero_s;
  logic              addr_inc_s;
  logic              capture_s;
  logic              scan_done_s;

  // Scan sequencing: SCAN issues the read, WAIT inspects the word, OUT holds it until accepted.
  always_comb begin
    st_next_s   = st_r;
    addr_inc_s  = 1'b0;
    capture_s   = 1'b0;
    scan_done_s = 1'b0;
    last_s      = (addr_r == LAST_ADDR);
    nonzero_s   = (mem_rdata != {DATA_W{1'b0}});
    case (st_r)
      IDLE: begin
        if (scan_start) st_next_s = SCAN;
        else            st_next_s = IDLE;
      end
      SCAN: st_next_s = WAIT;
      WAIT: begin
        if (nonzero_s) begin
          st_next_s = OUT;
          capture_s = 1'b1;
        end else if (last_s) begin
          st_next_s   = IDLE;
          scan_done_s = 1'b1;
        end else begin
          st_next_s  = SCAN;
          addr_inc_s = 1'b1;
        end
      end
      OUT: begin
        if (dump_ready) begin
          if (last_s) begin
            st_next_s   = IDLE;
            scan_done_s = 1'b1;
          end else begin
            st_next_s  = SCAN;
            addr_inc_s = 1'b1;
          end
        end else begin
          st_next_s = OUT;
        end
      end
      default: st_next_s = IDLE;
    endcase
  end

  // State, address counter and registered memory/dump outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_r        <= IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      rd_en_r     <= 1'b0;
      valid_r     <= 1'b0;
      dump_addr_r <= {ADDR_W{1'b0}};
      dump_data_r <= {DATA_W{1'b0}};
    end else begin
      st_r    <= st_next_s;
      rd_en_r <= (st_next_s == SCAN);
      valid_r <= (st_next_s == OUT);
      if ((st_r == IDLE) && scan_start) begin
        addr_r <= {ADDR_W{1'b0}};
      end else if (addr_inc_s) begin
        addr_r <= addr_r + ADDR_W'(1'b1);
      end else begin
        addr_r <= addr_r;
      end
      if (capture_s) begin
        dump_addr_r <= addr_r;
        dump_data_r <= mem_rdata;
      end else begin
        dump_addr_r <= dump_addr_r;
        dump_data_r <= dump_data_r;
      end
    end
  end

  assign mem_rd_en  = rd_en_r;
  assign mem_addr   = addr_r;
  assign dump_valid = valid_r;
  assign dump_addr  = dump_addr_r;
  assign dump_data  = dump_data_r;
  assign scan_done  = scan_done_s;

endmodule

// File: rtl/cpu_run_dump_ctrl.sv
// Run sequencer for the 16-bit CPU: reset, run to HALT or cycle limit, drain, then dump nonzero memory.
// Owns the data-memory read port only while cpu_run is low.
module cpu_run_dump_ctrl #(
  parameter int         ADDR_W       = 16,
  parameter int         DATA_W       = 16,
  parameter int         RESET_CYCLES = 4,
  parameter int         DRAIN_CYCLES = 10,
  parameter int         MAX_CYCLES   = 1000000,
  parameter logic [4:0] HALT_OP      = cpu_ctrl_pkg::HALT_OP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] instr,
  output logic              cpu_reset,
  output logic              cpu_run,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       cycle_count
);
  import cpu_ctrl_pkg::*;

  localparam logic [15:0] RST_LAST   = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);
  localparam logic [31:0] RUN_LIMIT  = 32'(MAX_CYCLES - 1);

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] phase_cnt_r;
  logic [31:0] cycle_count_r;
  logic        timeout_r;
  logic        cpu_reset_r;
  logic        cpu_run_r;
  logic        busy_r;
  logic        done_r;
  logic        halt_s;
  logic        limit_s;
  logic        start_acc_s;
  logic        scan_start_s;
  logic        scan_done_s;

  // Top-level phase sequencing; halt beats the cycle limit when both land together.
  always_comb begin
    next_state_s = state_r;
    start_acc_s  = 1'b0;
    scan_start_s = 1'b0;
    halt_s       = is_halt(instr[15:0], HALT_OP);
    limit_s      = (cycle_count_r == RUN_LIMIT);
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          next_state_s = RST;
          start_acc_s  = 1'b1;
        end else begin
          next_state_s = state_r;
        end
      end
      RST: begin
        if (phase_cnt_r == RST_LAST) next_state_s = RUN;
        else                         next_state_s = RST;
      end
      RUN: begin
        if (halt_s || limit_s) next_state_s = DRAIN;
        else                   next_state_s = RUN;
      end
      DRAIN: begin
        if (phase_cnt_r == DRAIN_LAST) begin
          next_state_s = SCAN;
          scan_start_s = 1'b1;
        end else begin
          next_state_s = DRAIN;
        end
      end
      SCAN: begin
        if (scan_done_s) next_state_s = DONE;
        else             next_state_s = SCAN;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, phase/run counters, sticky timeout and registered core controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      phase_cnt_r   <= 16'd0;
      cycle_count_r <= 32'd0;
      timeout_r     <= 1'b0;
      cpu_reset_r   <= 1'b1;
      cpu_run_r     <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (next_state_s != state_r) phase_cnt_r <= 16'd0;
      else                         phase_cnt_r <= phase_cnt_r + 16'd1;
      if (start_acc_s) begin
        cycle_count_r <= 32'd0;
        timeout_r     <= 1'b0;
      end else if (state_r == RUN) begin
        if (cycle_count_r != 32'hFFFF_FFFF) cycle_count_r <= cycle_count_r + 32'd1;
        else                                cycle_count_r <= cycle_count_r;
        if (limit_s && !halt_s) timeout_r <= 1'b1;
        else                    timeout_r <= timeout_r;
      end else begin
        cycle_count_r <= cycle_count_r;
        timeout_r     <= timeout_r;
      end
      // Decoding next_state keeps cpu_run low in the very cycle the scan starts reading.
      cpu_reset_r <= (next_state_s == IDLE) || (next_state_s == RST);
      cpu_run_r   <= (next_state_s == RUN) || (next_state_s == DRAIN);
      busy_r      <= (next_state_s != IDLE) && (next_state_s != DONE);
      done_r      <= (next_state_s == DONE);
    end
  end

  mem_scan_streamer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_scan (
    .clk        (clk),
    .reset      (reset),
    .scan_start (scan_start_s),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .scan_done  (scan_done_s)
  );

  assign cpu_reset   = cpu_reset_r;
  assign cpu_run     = cpu_run_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign timeout     = timeout_r;
  assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_cpu_run_dump_ctrl.sv
// Self-checking bench for cpu_run_dump_ctrl: table rows, randomized runs against a run/dump model,
// and hand-written reset-abort sequences.
module tb_cpu_run_dump_ctrl;
  localparam int ADDR_W       = 8;
  localparam int DATA_W       = 16;
  localparam int RESET_CYCLES = 4;
  localparam int DRAIN_CYCLES = 10;
  localparam int MAX_CYCLES   = 20;
  localparam int NWORDS       = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset, start, dump_ready;
  logic [DATA_W-1:0] instr, mem_rdata;
  logic              cpu_reset, cpu_run, mem_rd_en, dump_valid, busy, done, timeout;
  logic [ADDR_W-1:0] mem_addr, dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic [31:0]       cycle_count;
  logic [DATA_W-1:0] mem [NWORDS];
  int                n_vec = 0;
  int                n_err = 0;

  typedef struct {
    int          halt_at;
    logic [15:0] halt_word;
    bit          decoy;
    int          ready_mode;
    int          mem_mode;
    int          exp_cc;
    bit          exp_to;
  } row_t;

  cpu_run_dump_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_CYCLES(RESET_CYCLES),
    .DRAIN_CYCLES(DRAIN_CYCLES), .MAX_CYCLES(MAX_CYCLES), .HALT_OP(5'b11100)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .cpu_reset(cpu_reset), .cpu_run(cpu_run), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .busy(busy), .done(done),
    .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory: word appears one cycle after the read strobe.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the run lasts up to and including the halt cycle, or MAX_CYCLES without one.
  function automatic int ref_cc(input int halt_at);
    return (halt_at < MAX_CYCLES) ? halt_at + 1 : MAX_CYCLES;
  endfunction

  function automatic bit ref_to(input int halt_at);
    return halt_at >= MAX_CYCLES;
  endfunction

  function automatic logic [15:0] noise();
    logic [15:0] w;
    w = 16'($urandom);
    while (w == 16'hE000 || w == 16'hE7FF) w = 16'($urandom);
    return w;
  endfunction

  task automatic fill_mem(input int mode);
    for (int a = 0; a < NWORDS; a++) begin
      if (mode == 1 && $urandom_range(0, 15) == 0) mem[a] = 16'($urandom_range(1, 65535));
      else                                          mem[a] = 16'h0000;
    end
    if (mode == 0) begin
      mem[3]        = 16'h1234;
      mem[NWORDS-1] = 16'hBEEF;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cpu_reset"}, cpu_reset, 1);
    chk({tag, "_cpu_run"}, cpu_run, 0);
    chk({tag, "_mem_rd_en"}, mem_rd_en, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_dump_valid"}, dump_valid, 0);
    chk({tag, "_dump_addr"}, dump_addr, 0);
    chk({tag, "_dump_data"}, dump_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  // One complete run from IDLE/DONE; abort_mode 1 resets mid-RUN, 2 resets at the first dump beat.
  task automatic run_one(input string tag, input int halt_at, input logic [15:0] hw, input bit decoy,
                         input int ready_mode, input int abort_mode, input int exp_cc, input bit exp_to);
    logic [ADDR_W-1:0] qa[$];
    logic [DATA_W-1:0] qd[$];
    int rst_hi = 0, run_hi = 0, scan_cyc = 0, out_cyc = 0, rd_cnt = 0, stall = 0;
    int since_beat = -1, cyc = 0, n_beats = 0, exp_beats;
    bit prev_stall = 0, seen_run = 0, got_done = 0, order_ok = 1, excl_ok = 1, busy_ok = 1, rdy;
    logic [ADDR_W-1:0] prev_a = '0;
    logic [DATA_W-1:0] prev_d = '0;
    for (int a = 0; a < NWORDS; a++)
      if (mem[a] != 16'h0000) begin
        qa.push_back(ADDR_W'(a));
        qd.push_back(mem[a]);
      end
    exp_beats = qa.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_start_done_clr"}, done, 0);
    chk({tag, "_start_to_clr"}, timeout, 0);
    chk({tag, "_start_cc_clr"}, cycle_count, 0);
    chk({tag, "_start_busy"}, busy, 1);
    while (!got_done && cyc < 3000) begin
      if (since_beat >= 0) since_beat++;
      if (done) begin
        got_done = 1;
        break;
      end
      if (!busy) busy_ok = 0;
      if (cpu_reset && !seen_run) rst_hi++;
      if (cpu_run) begin
        seen_run = 1;
        if (run_hi == halt_at)                  instr = hw;
        else if (decoy && run_hi == halt_at - 2) instr = 16'hE001;
        else if (decoy && run_hi == halt_at - 1) instr = 16'hE400;
        else                                     instr = noise();
        run_hi++;
      end else begin
        instr = noise();
      end
      if (abort_mode == 1 && cpu_run && run_hi == 3) begin
        reset = 1'b1;
        #1 check_reset_vals({tag, "_mid_run"});
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (abort_mode == 2 && dump_valid) begin
        reset = 1'b1;
        #1 check_reset_vals({tag, "_mid_out"});
        @(negedge clk);
        reset = 1'b0;
        dump_ready = 1'b0;
        return;
      end
      if (mem_rd_en && cpu_run) excl_ok = 0;
      if (mem_rd_en) begin
        if (mem_addr != ADDR_W'(rd_cnt)) order_ok = 0;
        rd_cnt++;
      end
      if (busy && !cpu_run && !cpu_reset) scan_cyc++;
      if (prev_stall) begin
        chk({tag, "_hold_valid"}, dump_valid, 1);
        chk({tag, "_hold_addr"}, dump_addr, prev_a);
        chk({tag, "_hold_data"}, dump_data, prev_d);
      end
      if (dump_valid) begin
        out_cyc++;
        if (ready_mode == 0)      rdy = 1;
        else if (ready_mode == 1) rdy = ($urandom_range(0, 1) == 1);
        else                      rdy = (stall >= 5);
        dump_ready = rdy;
        if (rdy) begin
          n_beats++;
          stall = 0;
          since_beat = 0;
          if (qa.size() > 0) begin
            chk({tag, "_beat_addr"}, dump_addr, qa.pop_front());
            chk({tag, "_beat_data"}, dump_data, qd.pop_front());
          end
        end else begin
          stall++;
        end
        prev_stall = !rdy;
        prev_a = dump_addr;
        prev_d = dump_data;
      end else begin
        dump_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        prev_stall = 0;
      end
      start = (busy && $urandom_range(0, 7) == 0);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, got_done, 1);
    chk({tag, "_cycle_count"}, cycle_count, exp_cc);
    chk({tag, "_timeout"}, timeout, exp_to);
    chk({tag, "_reset_cycles"}, rst_hi, RESET_CYCLES);
    chk({tag, "_run_cycles"}, run_hi, exp_cc + DRAIN_CYCLES);
    chk({tag, "_beats"}, n_beats, exp_beats);
    chk({tag, "_reads"}, rd_cnt, NWORDS);
    chk({tag, "_read_order"}, order_ok, 1);
    chk({tag, "_rd_vs_run"}, excl_ok, 1);
    chk({tag, "_busy_during"}, busy_ok, 1);
    chk({tag, "_scan_cycles"}, scan_cyc, 2 * NWORDS + out_cyc);
    chk({tag, "_end_busy"}, busy, 0);
    chk({tag, "_end_cpu_run"}, cpu_run, 0);
    chk({tag, "_end_cpu_reset"}, cpu_reset, 0);
    if (mem[NWORDS-1] != 16'h0000) chk({tag, "_done_after_last"}, since_beat, 1);
  endtask

  initial begin
    row_t rows[6];
    rows[0] = '{7,    16'hE000, 1'b0, 0, 0, 8,  1'b0};
    rows[1] = '{5,    16'hE7FF, 1'b1, 0, 1, 6,  1'b0};
    rows[2] = '{2,    16'hE000, 1'b0, 2, 0, 3,  1'b0};
    rows[3] = '{1000, 16'hE000, 1'b0, 1, 1, 20, 1'b1};
    rows[4] = '{19,   16'hE7FF, 1'b0, 0, 1, 20, 1'b0};
    rows[5] = '{0,    16'hE000, 1'b0, 1, 2, 1,  1'b0};

    reset = 1'b1;
    start = 1'b0;
    dump_ready = 1'b0;
    instr = 16'h0000;
    fill_mem(2);
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_cpu_reset", cpu_reset, 1);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 6; i++) begin
      fill_mem(rows[i].mem_mode);
      run_one($sformatf("row%0d", i), rows[i].halt_at, rows[i].halt_word, rows[i].decoy,
              rows[i].ready_mode, 0, rows[i].exp_cc, rows[i].exp_to);
    end

    for (int r = 0; r < 6; r++) begin
      int h;
      logic [15:0] hw;
      h  = $urandom_range(0, 25);
      hw = ($urandom_range(0, 1) == 1) ? 16'hE7FF : 16'hE000;
      fill_mem(1);
      run_one($sformatf("rand%0d", r), h, hw, 1'b0, $urandom_range(0, 2), 0, ref_cc(h), ref_to(h));
    end

    fill_mem(0);
    run_one("abort_run", 10, 16'hE000, 1'b0, 0, 1, 0, 1'b0);
    run_one("abort_out", 4, 16'hE000, 1'b0, 2, 2, 0, 1'b0);
    run_one("recover", 4, 16'hE7FF, 1'b0, 0, 0, 5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
